// File: rtl/toggle_event_pkg.sv
`default_nettype none
// ============================================================================
// Module      : toggle_event_pkg
// Description : Shared types and helpers for the toggle-event receive path.
//               state_e     - decoder FSM encoding (INIT priming, RUN detect)
//               arm_cycles  - priming length for a given synchronizer depth
//               max_count   - saturation value of a CW-bit pending counter
// Revision    : 1.0 - initial release
// ============================================================================
package toggle_event_pkg;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Arm counter is wide enough for the largest legal priming length (4+1).
    localparam int ARM_CNT_W = 3;

    // The synchronized level and its delayed copy are both valid only after
    // the chain depth plus the edge register have been flushed.
    function automatic int arm_cycles(input int sync_stages);
        return sync_stages + 1;
    endfunction

    function automatic int max_count(input int cw);
        return (1 << cw) - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_chain.sv
`default_nettype none
// ============================================================================
// Module      : sync_chain
// Description : Multi-flop level synchronizer for a single asynchronous bit.
// Ports       : clk   - destination clock
//               rst_n - asynchronous active-low reset (chain clears to 0)
//               d     - asynchronous input level
//               q     - synchronized level, STAGES clk edges behind d
// Revision    : 1.0 - initial release
// ============================================================================
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d};
        end
    end

    assign q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/toggle_event_decoder.sv
`default_nettype none
// ============================================================================
// Module      : toggle_event_decoder
// Description : Receive side of a toggle-signalled event path. Synchronizes
//               the remote toggle level, turns every transition into one
//               event pulse and buffers events in a saturating counter that
//               a consumer drains through a valid/ready handshake.
// Ports       : clk       - clock, all state on rising edge
//               rst_n     - asynchronous active-low reset
//               tog_in    - toggle level from remote T flip-flop (async)
//               evt_ready - consumer takes one event when evt_valid=1
//               clr_ovf   - synchronous clear of overflow
//               armed     - priming complete, detection enabled
//               evt_pulse - registered one-cycle pulse per toggle
//               evt_valid - pending count nonzero
//               evt_count - pending event count
//               overflow  - sticky, toggle seen while count saturated
// Revision    : 1.0 - initial release
// ============================================================================
module toggle_event_decoder
    import toggle_event_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CW          = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tog_in,
    input  logic          evt_ready,
    input  logic          clr_ovf,
    output logic          armed,
    output logic          evt_pulse,
    output logic          evt_valid,
    output logic [CW-1:0] evt_count,
    output logic          overflow
);

    localparam logic [0:0]           C_ST_INIT  = ST_INIT;
    localparam logic [0:0]           C_ST_RUN   = ST_RUN;
    localparam logic [ARM_CNT_W-1:0] C_ARM_LAST = ARM_CNT_W'(arm_cycles(SYNC_STAGES) - 1);
    localparam logic [CW-1:0]        C_MAX      = CW'(max_count(CW));

    logic                 w_ss;
    logic                 r_prev;
    logic [0:0]           r_state;
    logic [ARM_CNT_W-1:0] r_arm_cnt;
    logic                 r_armed;
    logic                 r_pulse;
    logic [CW-1:0]        r_count;
    logic                 r_ovf;

    logic                 w_inc;
    logic                 w_dec;
    logic                 w_ovf_set;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (tog_in),
        .q     (w_ss)
    );

    // Edge register runs in every state so it already holds the settled
    // level by the time RUN starts comparing against it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_ss;
        end
    end

    // INIT waits until the chain and edge register have flushed, so a level
    // already high at reset release is absorbed instead of reported.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= C_ST_INIT;
            r_arm_cnt <= '0;
            r_armed   <= 1'b0;
        end else if (r_state == C_ST_INIT) begin
            r_arm_cnt <= r_arm_cnt + ARM_CNT_W'(1);
            if (r_arm_cnt == C_ARM_LAST) begin
                r_state <= C_ST_RUN;
                r_armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= (r_state == C_ST_RUN) && (w_ss ^ r_prev);
        end
    end

    assign w_inc     = r_pulse;
    assign w_dec     = evt_valid & evt_ready;
    // A simultaneous take leaves room for the new event, so no overflow.
    assign w_ovf_set = w_inc & ~w_dec & (r_count == C_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_inc && !w_dec && (r_count != C_MAX)) begin
            r_count <= r_count + CW'(1);
        end else if (w_dec && !w_inc) begin
            r_count <= r_count - CW'(1);
        end
    end

    // Set wins over clear so an event lost in the clearing cycle is still
    // reported.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= w_ovf_set | (r_ovf & ~clr_ovf);
        end
    end

    assign armed     = r_armed;
    assign evt_pulse = r_pulse;
    assign evt_count = r_count;
    assign evt_valid = (r_count != '0);
    assign overflow  = r_ovf;

endmodule
`default_nettype wire
